imm_offs_stage: RTL



---
 rtl/imm_offs_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/imm_offs_stage.sv
// Per-lane immediate / branch-offset / target generator between ID and EX.
// Results are computed at the input and held in a 2-entry (main + skid) FIFO.
module imm_offs_stage #(
    parameter int unsigned WORD  = 32,
    parameter int unsigned LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*WORD-1:0] in_inst,
    input  logic [WORD-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*WORD-1:0] out_imm,
    output logic [LANES*WORD-1:0] out_offs,
    output logic [LANES*WORD-1:0] out_tgt,
    output logic [LANES-1:0]      out_undef,
    output logic [WORD-1:0]       out_pc
);

    typedef struct packed {
        logic [LANES*WORD-1:0] imm;
        logic [LANES*WORD-1:0] offs;
        logic [LANES*WORD-1:0] tgt;
        logic [LANES-1:0]      undef;
        logic [WORD-1:0]       pc;
    } bundle_t;

    // Key = {inst[30:28], inst[25], inst[22]}, priority from the top bit down.
    function automatic logic [WORD-1:0] imm_of(input logic [WORD-1:0] inst);
        logic [WORD-1:0] imm;
        imm = '0;
        if (inst[30]) begin
            imm = 32'h4;
        end else if (inst[29]) begin
            imm = {{20{inst[21]}}, inst[21:10]};
        end else if (inst[28]) begin
            imm = {{12{inst[24]}}, inst[24:5]};
        end else if (inst[25]) begin
            imm = inst[24] ? {{20{inst[21]}}, inst[21:10]} : {20'b0, inst[21:10]};
        end else if (inst[22]) begin
            imm = {27'b0, inst[14:10]};
        end
        return imm;
    endfunction

    function automatic logic undef_of(input logic [WORD-1:0] inst);
        return (inst[30:28] == 3'b000) && !inst[25] && !inst[22];
    endfunction

    function automatic logic [WORD-1:0] offs_of(input logic [WORD-1:0] inst);
        logic [WORD-1:0] offs;
        if (inst[31:27] == 5'b01010) begin
            offs = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
        end else begin
            offs = {{14{inst[25]}}, inst[25:10], 2'b00};
        end
        return offs;
    endfunction

    bundle_t w_new;
    bundle_t r_m;
    bundle_t r_s;
    logic    r_m_valid;
    logic    r_s_valid;
    logic    w_accept;
    logic    w_pop;

    always_comb begin
        w_new    = '0;
        w_new.pc = in_pc;
        for (int k = 0; k < LANES; k++) begin
            w_new.imm[k*WORD +: WORD]  = imm_of(in_inst[k*WORD +: WORD]);
            w_new.offs[k*WORD +: WORD] = offs_of(in_inst[k*WORD +: WORD]);
            w_new.tgt[k*WORD +: WORD]  = in_pc + WORD'(4 * k) + offs_of(in_inst[k*WORD +: WORD]);
            w_new.undef[k]             = undef_of(in_inst[k*WORD +: WORD]);
        end
    end

    // Skid occupancy is a register, so in_ready never depends on out_ready.
    assign in_ready = ~r_s_valid;
    assign w_accept = in_valid & in_ready;
    assign w_pop    = r_m_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m       <= '0;
            r_s       <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_m_valid || w_pop) begin
            if (r_s_valid) begin
                r_m       <= r_s;
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end else begin
                r_m_valid <= w_accept;
                if (w_accept) begin
                    r_m <= w_new;
                end
            end
        end else if (w_accept) begin
            r_s       <= w_new;
            r_s_valid <= 1'b1;
        end
    end

    assign out_valid = r_m_valid;
    assign out_imm   = r_m.imm;
    assign out_offs  = r_m.offs;
    assign out_tgt   = r_m.tgt;
    assign out_undef = r_m.undef;
    assign out_pc    = r_m.pc;

endmodule
